// File: rtl/bird_ypos_ctl.sv
// Vertical motion controller for the player rectangle: synchronizes the jump
// button and applies jump impulse, gravity and screen clamps once per physics tick.
module bird_ypos_ctl #(
    parameter int TICK_CYCLES = 1_083_333,
    parameter int Y_START     = 300,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 708,
    parameter int JUMP_VEL    = -8,
    parameter int GRAVITY     = 1,
    parameter int V_MAX       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump,
    input  logic        endgame,
    output logic [11:0] ypos,
    output logic [7:0]  vel,
    output logic        playing,
    output logic        ground_hit,
    output logic [1:0]  state_dbg,
    output logic        tick_dbg
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [11:0] Y_START12 = 12'(Y_START);
    localparam logic signed [12:0] Y_MIN13 = 13'(Y_MIN);
    localparam logic signed [12:0] Y_MAX13 = 13'(Y_MAX);
    localparam logic [7:0] JUMP8 = 8'(JUMP_VEL);
    localparam logic signed [8:0] GRAV9 = 9'(GRAVITY);
    localparam logic signed [8:0] V_MAX9 = 9'(V_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic jump_s1_q, jump_s1_d;
    logic jump_s2_q, jump_s2_d;
    logic jump_s3_q, jump_s3_d;
    logic jump_pulse_q, jump_pulse_d;
    logic jump_pending_q, jump_pending_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0] ypos_q, ypos_d;
    logic [7:0] vel_q, vel_d;
    logic playing_q, playing_d;
    logic ground_hit_q, ground_hit_d;

    logic tick;
    logic signed [8:0] vel_inc;
    logic [7:0] vel_fall;
    logic [7:0] v_next;
    logic signed [12:0] y_next;

    // jump_s3 holds the previous synchronized level for edge detection.
    always_comb begin
        jump_s1_d    = jump;
        jump_s2_d    = jump_s1_q;
        jump_s3_d    = jump_s2_q;
        jump_pulse_d = jump_s2_q & ~jump_s3_q;
    end

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        vel_inc  = $signed({vel_q[7], vel_q}) + GRAV9;
        vel_fall = (vel_inc > V_MAX9) ? V_MAX9[7:0] : vel_inc[7:0];
        v_next   = (jump_pending_q | jump_pulse_q) ? JUMP8 : vel_fall;
        y_next   = $signed({1'b0, ypos_q}) + $signed({{5{v_next[7]}}, v_next});
    end

    always_comb begin
        state_d        = state_q;
        ypos_d         = ypos_q;
        vel_d          = vel_q;
        ground_hit_d   = ground_hit_q;
        jump_pending_d = jump_pending_q;
        unique case (state_q)
            S_IDLE: begin
                ypos_d = Y_START12;
                vel_d  = '0;
                if (jump_pulse_q) begin
                    jump_pending_d = 1'b1;
                    state_d        = S_FLY;
                end
            end
            S_FLY: begin
                if (endgame) begin
                    state_d        = S_DEAD;
                    jump_pending_d = 1'b0;
                end else if (tick) begin
                    jump_pending_d = 1'b0;
                    if (y_next <= Y_MIN13) begin
                        ypos_d = Y_MIN13[11:0];
                        vel_d  = '0;
                    end else if (y_next >= Y_MAX13) begin
                        ypos_d       = Y_MAX13[11:0];
                        vel_d        = '0;
                        ground_hit_d = 1'b1;
                        state_d      = S_DEAD;
                    end else begin
                        ypos_d = y_next[11:0];
                        vel_d  = v_next;
                    end
                end else begin
                    jump_pending_d = jump_pending_q | jump_pulse_q;
                end
            end
            S_DEAD: begin
                jump_pending_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        playing_d = (state_d == S_FLY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            jump_s1_q      <= 1'b0;
            jump_s2_q      <= 1'b0;
            jump_s3_q      <= 1'b0;
            jump_pulse_q   <= 1'b0;
            jump_pending_q <= 1'b0;
            cnt_q          <= '0;
            ypos_q         <= Y_START12;
            vel_q          <= '0;
            playing_q      <= 1'b0;
            ground_hit_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            jump_s1_q      <= jump_s1_d;
            jump_s2_q      <= jump_s2_d;
            jump_s3_q      <= jump_s3_d;
            jump_pulse_q   <= jump_pulse_d;
            jump_pending_q <= jump_pending_d;
            cnt_q          <= cnt_d;
            ypos_q         <= ypos_d;
            vel_q          <= vel_d;
            playing_q      <= playing_d;
            ground_hit_q   <= ground_hit_d;
        end
    end

    assign ypos       = ypos_q;
    assign vel        = vel_q;
    assign playing    = playing_q;
    assign ground_hit = ground_hit_q;
    assign state_dbg  = state_q;
    assign tick_dbg   = tick;

endmodule

// File: tb/tb_bird_ypos_ctl.sv
// Directed bench for bird_ypos_ctl with a 4-cycle physics tick: idle, jump arc,
// terminal velocity, ground, ceiling clamp and endgame freeze.
module tb_bird_ypos_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic        endgame;
    logic [11:0] ypos;
    logic [7:0]  vel;
    logic        playing;
    logic        ground_hit;
    logic [1:0]  state_dbg;
    logic        tick_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FLY  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    bird_ypos_ctl #(.TICK_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .jump(jump), .endgame(endgame),
        .ypos(ypos), .vel(vel), .playing(playing), .ground_hit(ground_hit),
        .state_dbg(state_dbg), .tick_dbg(tick_dbg)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int y, input int v);
        chk({tag, "_ypos"}, {20'd0, ypos}, 32'(y));
        chk({tag, "_vel"}, {24'd0, vel}, {24'd0, 8'(v)});
    endtask

    // Leaves the bench sampling inside a tick cycle.
    task automatic align_tick();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (tick_dbg) found = 1'b1;
            else step(1);
        end
        chk("tick_timeout", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_tick();
        align_tick();
        step(1);
    endtask

    task automatic press_tick();
        jump = 1'b1;
        step(1);
        jump = 1'b0;
        wait_tick();
    endtask

    int exp_y[19] = '{292, 285, 279, 274, 270, 267, 265, 264, 264, 265,
                      267, 270, 274, 279, 285, 292, 300, 309, 319};

    initial begin
        rst = 1'b1;
        jump = 1'b0;
        endgame = 1'b0;
        step(2);
        chk_pos("reset", 300, 0);
        chk("reset_playing", {31'd0, playing}, 32'd0);
        chk("reset_ground", {31'd0, ground_hit}, 32'd0);
        chk("reset_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        rst = 1'b0;

        for (int n = 1; n <= 20; n++) begin
            step(1);
            chk_pos("idle", 300, 0);
            chk("idle_playing", {31'd0, playing}, 32'd0);
            chk("idle_ground", {31'd0, ground_hit}, 32'd0);
            chk("idle_tick", {31'd0, tick_dbg}, ((n % 4) == 3) ? 32'd1 : 32'd0);
        end

        // Pin rise to playing takes four edges.
        jump = 1'b1;
        step(1);
        jump = 1'b0;
        step(2);
        chk("start_playing_early", {31'd0, playing}, 32'd0);
        step(1);
        chk("start_playing", {31'd0, playing}, 32'd1);
        chk("start_state", {30'd0, state_dbg}, {30'd0, ST_FLY});

        for (int i = 0; i < 19; i++) begin
            wait_tick();
            chk_pos("arc", exp_y[i], i - 8);
        end
        for (int k = 1; k <= 38; k++) begin
            wait_tick();
            chk_pos("fall", 319 + 10 * k, 10);
        end
        wait_tick();
        chk_pos("ground", 708, 0);
        chk("ground_hit", {31'd0, ground_hit}, 32'd1);
        chk("ground_playing", {31'd0, playing}, 32'd0);
        chk("ground_state", {30'd0, state_dbg}, {30'd0, ST_DEAD});
        jump = 1'b1;
        step(1);
        jump = 1'b0;
        step(12);
        chk_pos("dead_jump", 708, 0);
        chk("dead_state", {30'd0, state_dbg}, {30'd0, ST_DEAD});
        chk("dead_ground", {31'd0, ground_hit}, 32'd1);

        // Ceiling: jump every tick from the start position.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_pos("rst_dead", 300, 0);
        chk("rst_dead_ground", {31'd0, ground_hit}, 32'd0);
        chk("rst_dead_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        press_tick();
        chk("ceil_enter", {30'd0, state_dbg}, {30'd0, ST_FLY});
        chk_pos("ceil_enter", 300, 0);
        wait_tick();
        chk_pos("ceil_first", 292, -8);
        for (int k = 2; k <= 35; k++) begin
            press_tick();
            chk_pos("ceil_climb", 300 - 8 * k, -8);
        end
        press_tick();
        chk_pos("ceil_12", 12, -8);
        press_tick();
        chk_pos("ceil_4", 4, -8);
        press_tick();
        chk_pos("ceil_clamp", 0, 0);
        press_tick();
        chk_pos("ceil_hold", 0, 0);
        chk("ceil_state", {30'd0, state_dbg}, {30'd0, ST_FLY});

        // Endgame: reach y=250 then collide on a tick.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        press_tick();
        wait_tick();
        chk_pos("eg_first", 292, -8);
        for (int k = 2; k <= 4; k++) begin
            press_tick();
            chk_pos("eg_climb", 300 - 8 * k, -8);
        end
        wait_tick();
        chk_pos("eg_g1", 261, -7);
        wait_tick();
        chk_pos("eg_g2", 255, -6);
        wait_tick();
        chk_pos("eg_g3", 250, -5);
        align_tick();
        endgame = 1'b1;
        step(1);
        endgame = 1'b0;
        chk_pos("eg_freeze", 250, -5);
        chk("eg_playing", {31'd0, playing}, 32'd0);
        chk("eg_state", {30'd0, state_dbg}, {30'd0, ST_DEAD});
        chk("eg_ground", {31'd0, ground_hit}, 32'd0);
        wait_tick();
        chk_pos("eg_hold", 250, -5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_pos("eg_rst", 300, 0);
        chk("eg_rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        chk("eg_rst_playing", {31'd0, playing}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bird_ypos_ctl.md
# bird_ypos_ctl

Vertical motion controller for the player rectangle. It turns the jump button into a per-frame physics update (jump impulse, gravity, terminal velocity, ceiling clamp, ground detection). It publishes the rectangle's top-edge y coordinate, which the rectangle drawer uses for display and the obstacle controller consumes as its player y input for collision checks. It freezes on the obstacle controller's `endgame`.

## Interface
Parameters:
- `TICK_CYCLES`, 1_083_333: clk cycles per physics tick (~60 Hz at 65 MHz); must be ≥ 2.
- `Y_START`, 300: y at reset and in IDLE.
- `Y_MIN`, 0: ceiling limit for y.
- `Y_MAX`, 708: ground limit for y (screen height minus rectangle height).
- `JUMP_VEL`, -8: signed velocity loaded on a jump.
- `GRAVITY`, 1: velocity increment per tick.
- `V_MAX`, 10: terminal (maximum positive) velocity.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `jump` in 1: raw button, asynchronous to clk.
- `endgame` in 1: collision flag from the obstacle controller, level-sensitive.
- `ypos` out 12: top-edge y of the player rectangle, unsigned.
- `vel` out 8: current velocity, signed two's complement.
- `playing` out 1: high while in FLY.
- `ground_hit` out 1: sticky, set when y reaches `Y_MAX`.

## Operation
- Jump path:
  - `jump` passes through a 2-FF synchronizer, then a rising-edge register.
  - `jump_pulse` is a 1-cycle pulse on each synchronized 0→1 transition.
  - `jump_pending` is set by `jump_pulse` and cleared when a FLY tick consumes it.
  - Held buttons and multiple presses between ticks collapse into one jump.
- Tick counter:
  - Free-running 0..`TICK_CYCLES`-1 in every state.
  - `tick` is high exactly in the cycle where count == `TICK_CYCLES`-1.
  - The counter wraps to 0 on the following cycle.
- States:
  - IDLE: `ypos`=`Y_START`, `vel`=0. On `jump_pulse` go to FLY; `jump_pending` is set, so the first FLY tick applies the jump.
  - FLY, on `tick` with `endgame` low:
    - v' = `JUMP_VEL` if `jump_pending` (or `jump_pulse` in the same cycle); otherwise min(`vel`+`GRAVITY`, `V_MAX`).
    - y' = `ypos` + v', computed as 13-bit signed with `ypos` zero-extended and v' sign-extended.
    - If y' ≤ `Y_MIN`: `ypos`=`Y_MIN`, `vel`=0.
    - Else if y' ≥ `Y_MAX`: `ypos`=`Y_MAX`, `vel`=0, `ground_hit`=1, go to DEAD.
    - Else `ypos`=y', `vel`=v'.
  - FLY, on `endgame` high in any cycle: go to DEAD. `ypos` and `vel` hold and no update is applied.
  - DEAD: all outputs hold and `jump` is ignored. Only `rst` leaves DEAD.
- `playing` = (state == FLY), registered.
- `endgame` in IDLE has no effect. The obstacle controller cannot assert it before play starts.

## Timing
- Reset values: `ypos`=`Y_START`, `vel`=0, `playing`=0, `ground_hit`=0, state IDLE, synchronizers/`jump_pulse`/`jump_pending`=0, tick counter 0.
- `rst` mid-flight or in DEAD restores all reset values on the next edge.
- `jump` pin rise → `jump_pulse` high 3 cycles later (sync1, sync2, edge).
- IDLE→FLY: the state and `playing` update on the edge after `jump_pulse`.
- Physics: `ypos`/`vel` are computed in the `tick` cycle and visible on the next edge. All outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous events:
  - `jump_pulse` and `tick` in the same FLY cycle: the jump applies on this tick and `jump_pending` ends cleared.
  - `endgame` and `tick` in the same cycle: `endgame` wins and no physics update occurs.
  - Ceiling clamp and `jump_pending` together: clamp applies and `vel`=0.
- First period: the counter starts at 0 after reset, so the first `tick` comes `TICK_CYCLES` cycles after reset deassertion.

## Test plan
All scenarios use `TICK_CYCLES`=4 and defaults otherwise.
- Reset/idle: assert `rst` 2 cycles, then run 20 cycles with no `jump` → `ypos`=300, `vel`=0, `playing`=0, `ground_hit`=0 throughout; `tick` every 4th cycle.
- First jump: pulse `jump` → `playing`=1 four cycles after pin rise. Next tick → `ypos`=292, `vel`=-8. Following ticks → 285/-7, 279/-6, 274/-5.
- Gravity/terminal velocity: no further jumps → `vel` rises by 1 per tick and saturates at 10; `ypos` grows by 10 per tick once saturated.
- Ground: free-fall until y' ≥ 708 → `ypos`=708, `vel`=0, `ground_hit`=1, `playing`=0. A later `jump` press causes no change.
- Ceiling: press `jump` every tick from `ypos`=20 → `ypos` 12, 4, then 0 with `vel`=0, staying ≥ 0 (no wrap to 4095).
- Endgame: assert `endgame` in the same cycle as a `tick` at `ypos`=250 → `ypos` stays 250 and `playing`=0 next cycle. Then `rst` → `ypos`=300, state IDLE.
